wb_stage: RTL and testbench

Write-back stage of the mips789 pipeline: the writer side of the register bank's single write port. It registers the memory-stage result, aligns and sign/zero-extends load data, and drives wb_we/wb_addr/wb_din into the register file. A 2-entry buffer holds late results from the multi-cycle multiply/divide unit so they never collide with pipeline writes. It also supplies the aligned memory-stage value to the RF/EX forwarding muxes.

---
 rtl/wb_stage.sv | 151 +++++++++++++++
 tb/tb_wb_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: owns the register file's single write port. Arbitrates the
// pipeline result against a 2-entry buffer of late multiply/divide results.
module wb_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        pause,
  input  logic        mem_we_i,
  input  logic [4:0]  mem_addr_i,
  input  logic [31:0] mem_alu_i,
  input  logic [31:0] mem_dmem_i,
  input  logic [2:0]  mem_ld_ctl_i,
  input  logic [1:0]  mem_bsel_i,
  input  logic        md_valid_i,
  input  logic [4:0]  md_addr_i,
  input  logic [31:0] md_data_i,
  output logic        md_ready_o,
  output logic [31:0] fw_mem_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_din_o,
  output logic        busy_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  logic        st_valid;
  logic        st_pend;
  logic [4:0]  st_addr;
  logic [31:0] st_data;

  logic [DEPTH-1:0] ent_valid;
  logic [4:0]       ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic [4:0]  last_addr;
  logic [31:0] last_din;

  logic pipe_wr;
  logic buf_pop;
  logic buf_wr;
  logic push;

  // Big-endian load alignment; also feeds the forwarding muxes directly.
  always_comb begin
    byte_sel = mem_dmem_i[31:24];
    case (mem_bsel_i)
      2'b00:   byte_sel = mem_dmem_i[31:24];
      2'b01:   byte_sel = mem_dmem_i[23:16];
      2'b10:   byte_sel = mem_dmem_i[15:8];
      default: byte_sel = mem_dmem_i[7:0];
    endcase
    half_sel = mem_bsel_i[1] ? mem_dmem_i[15:0] : mem_dmem_i[31:16];
    case (mem_ld_ctl_i)
      3'b001:  fw_mem_o = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  fw_mem_o = {24'd0, byte_sel};
      3'b011:  fw_mem_o = {{16{half_sel[15]}}, half_sel};
      3'b100:  fw_mem_o = {16'd0, half_sel};
      3'b101:  fw_mem_o = mem_dmem_i;
      default: fw_mem_o = mem_alu_i;
    endcase
  end

  // pend marks a write not yet issued, so a held stage writes only once.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      st_valid <= 1'b0;
      st_pend  <= 1'b0;
      st_addr  <= 5'd0;
      st_data  <= 32'd0;
    end else if (!pause) begin
      st_valid <= mem_we_i & (mem_addr_i != 5'd0);
      st_pend  <= 1'b1;
      st_addr  <= mem_addr_i;
      st_data  <= fw_mem_o;
    end else begin
      st_pend  <= 1'b0;
    end
  end

  // md handshake: a result transfers on a clock edge where md_valid_i and
  // md_ready_o are both high; md_ready_o comes only from the registered count.
  assign md_ready_o = (count < 2'd2);
  assign busy_o     = (count != 2'd0);
  assign push       = md_valid_i & md_ready_o;

  assign pipe_wr = st_valid & st_pend;
  assign buf_pop = busy_o & ~pipe_wr;
  assign buf_wr  = buf_pop & ent_valid[rd_ptr];
  assign wb_we_o = pipe_wr | buf_wr;

  always_comb begin
    wb_addr_o = last_addr;
    wb_din_o  = last_din;
    if (pipe_wr) begin
      wb_addr_o = st_addr;
      wb_din_o  = st_data;
    end else if (buf_wr) begin
      wb_addr_o = ent_addr[rd_ptr];
      wb_din_o  = ent_data[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      last_addr <= 5'd0;
      last_din  <= 32'd0;
    end else if (wb_we_o) begin
      last_addr <= wb_addr_o;
      last_din  <= wb_din_o;
    end
  end

  // An issuing pipeline write is younger than any buffered result to the same
  // register, so matching entries are invalidated and later pop silently.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= 5'd0;
        ent_data[i] <= 32'd0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == 1'(i))) begin
          ent_valid[i] <= (md_addr_i != 5'd0);
          ent_addr[i]  <= md_addr_i;
          ent_data[i]  <= md_data_i;
        end else if (pipe_wr && (ent_addr[i] == st_addr)) begin
          ent_valid[i] <= 1'b0;
        end
      end
      if (push)    wr_ptr <= ~wr_ptr;
      if (buf_pop) rd_ptr <= ~rd_ptr;
      case ({push, buf_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed load/arbitration/squash/reset scenarios plus a
// random load phase; every register-file write is matched against exp_q.
module tb_wb_stage;

  logic        clk;
  logic        rst_i;
  logic        pause;
  logic        mem_we_i;
  logic [4:0]  mem_addr_i;
  logic [31:0] mem_alu_i;
  logic [31:0] mem_dmem_i;
  logic [2:0]  mem_ld_ctl_i;
  logic [1:0]  mem_bsel_i;
  logic        md_valid_i;
  logic [4:0]  md_addr_i;
  logic [31:0] md_data_i;
  logic        md_ready_o;
  logic [31:0] fw_mem_o;
  logic        wb_we_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_din_o;
  logic        busy_o;

  logic [36:0] exp_q[$];
  int n_checks;
  int n_fail;

  wb_stage dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .pause        (pause),
    .mem_we_i     (mem_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_alu_i    (mem_alu_i),
    .mem_dmem_i   (mem_dmem_i),
    .mem_ld_ctl_i (mem_ld_ctl_i),
    .mem_bsel_i   (mem_bsel_i),
    .md_valid_i   (md_valid_i),
    .md_addr_i    (md_addr_i),
    .md_data_i    (md_data_i),
    .md_ready_o   (md_ready_o),
    .fw_mem_o     (fw_mem_o),
    .wb_we_o      (wb_we_o),
    .wb_addr_o    (wb_addr_o),
    .wb_din_o     (wb_din_o),
    .busy_o       (busy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_align(input logic [2:0] ld, input logic [1:0] bsel,
                                              input logic [31:0] alu, input logic [31:0] dmem);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(dmem >> (8 * (3 - int'(bsel))));
    h = bsel[1] ? dmem[15:0] : dmem[31:16];
    case (ld)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'd0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'd0, h};
      3'd5:    return dmem;
      default: return alu;
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_mem(input logic we, input logic [4:0] addr, input logic [31:0] alu,
                           input logic [31:0] dmem, input logic [2:0] ld, input logic [1:0] bsel);
    mem_we_i     = we;
    mem_addr_i   = addr;
    mem_alu_i    = alu;
    mem_dmem_i   = dmem;
    mem_ld_ctl_i = ld;
    mem_bsel_i   = bsel;
  endtask

  task automatic drive_md(input logic valid, input logic [4:0] addr, input logic [31:0] data);
    md_valid_i = valid;
    md_addr_i  = addr;
    md_data_i  = data;
  endtask

  task automatic idle();
    drive_mem(1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 2'd0);
    drive_md(1'b0, 5'd0, 32'd0);
  endtask

  // scoreboard: every write-port write must match the queue head
  always @(negedge clk) begin
    if (rst_i && wb_we_o) begin
      if (exp_q.size() == 0)
        check("unexpected_write", {31'd0, wb_we_o, 27'd0, wb_addr_o}, 64'd0);
      else
        check("write", {27'd0, wb_addr_o, wb_din_o}, {27'd0, exp_q.pop_front()});
    end
  end

  initial begin
    logic        r_we;
    logic        r_pause;
    logic [4:0]  r_addr;
    logic [31:0] r_alu;
    logic [31:0] r_dmem;
    logic [2:0]  r_ld;
    logic [1:0]  r_bsel;
    logic [31:0] r_exp;

    n_checks = 0;
    n_fail   = 0;
    rst_i    = 1'b0;
    pause    = 1'b0;
    idle();
    #1;
    check("rst_we", {63'd0, wb_we_o}, 64'd0);
    check("rst_addr", {59'd0, wb_addr_o}, 64'd0);
    check("rst_din", {32'd0, wb_din_o}, 64'd0);
    check("rst_ready", {63'd0, md_ready_o}, 64'd1);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    tick();
    tick();
    rst_i = 1'b1;
    tick();

    // load alignment
    drive_mem(1'b1, 5'd5, 32'd0, 32'h12F45678, 3'd1, 2'b01);
    #1 check("fw_lb", {32'd0, fw_mem_o}, 64'hFFFFFFF4);
    exp_q.push_back({5'd5, 32'hFFFFFFF4});
    tick();
    drive_mem(1'b1, 5'd5, 32'd0, 32'h12F45678, 3'd2, 2'b01);
    exp_q.push_back({5'd5, 32'h000000F4});
    tick();
    drive_mem(1'b1, 5'd6, 32'd0, 32'h12F45678, 3'd3, 2'b10);
    exp_q.push_back({5'd6, 32'h00005678});
    tick();

    // r0 suppression
    drive_mem(1'b1, 5'd0, 32'hDEADBEEF, 32'd0, 3'd0, 2'd0);
    tick();
    idle();
    drive_md(1'b1, 5'd0, 32'h55);
    tick();
    idle();
    tick();
    tick();
    check("r0_busy", {63'd0, busy_o}, 64'd0);

    // arbitration: pipeline first, then buffer
    drive_mem(1'b1, 5'd3, 32'h22, 32'd0, 3'd0, 2'd0);
    drive_md(1'b1, 5'd7, 32'h11);
    exp_q.push_back({5'd3, 32'h22});
    exp_q.push_back({5'd7, 32'h11});
    tick();
    idle();
    tick();
    check("arb_busy_mid", {63'd0, busy_o}, 64'd1);
    tick();
    check("arb_busy_end", {63'd0, busy_o}, 64'd0);
    check("hold_addr", {58'd0, wb_we_o, wb_addr_o}, {58'd0, 1'b0, 5'd7});
    check("hold_din", {32'd0, wb_din_o}, 64'h11);

    // full buffer, then pause drains it
    drive_mem(1'b1, 5'd1, 32'h101, 32'd0, 3'd0, 2'd0);
    drive_md(1'b1, 5'd20, 32'hA0);
    exp_q.push_back({5'd1, 32'h101});
    tick();
    drive_mem(1'b1, 5'd2, 32'h102, 32'd0, 3'd0, 2'd0);
    drive_md(1'b1, 5'd21, 32'hA1);
    exp_q.push_back({5'd2, 32'h102});
    tick();
    check("full_ready", {63'd0, md_ready_o}, 64'd0);
    drive_mem(1'b1, 5'd3, 32'h103, 32'd0, 3'd0, 2'd0);
    drive_md(1'b1, 5'd22, 32'hA2);
    exp_q.push_back({5'd3, 32'h103});
    tick();
    check("full_ready_hold", {63'd0, md_ready_o}, 64'd0);
    drive_md(1'b0, 5'd0, 32'd0);
    drive_mem(1'b1, 5'd4, 32'h104, 32'd0, 3'd0, 2'd0);
    pause = 1'b1;
    exp_q.push_back({5'd20, 32'hA0});
    exp_q.push_back({5'd21, 32'hA1});
    tick();
    check("pop_cycle_ready", {63'd0, md_ready_o}, 64'd0);
    tick();
    check("after_pop_ready", {63'd0, md_ready_o}, 64'd1);
    tick();
    check("drain_busy", {63'd0, busy_o}, 64'd0);
    idle();
    pause = 1'b0;
    tick();

    // WAW squash
    drive_mem(1'b1, 5'd9, 32'hBB, 32'd0, 3'd0, 2'd0);
    drive_md(1'b1, 5'd9, 32'hAA);
    exp_q.push_back({5'd9, 32'hBB});
    tick();
    idle();
    tick();
    check("squash_we", {63'd0, wb_we_o}, 64'd0);
    check("squash_busy", {63'd0, busy_o}, 64'd1);
    tick();
    check("squash_busy_end", {63'd0, busy_o}, 64'd0);

    // async reset with a full buffer
    drive_mem(1'b1, 5'd10, 32'h10A, 32'd0, 3'd0, 2'd0);
    drive_md(1'b1, 5'd11, 32'hB1);
    exp_q.push_back({5'd10, 32'h10A});
    tick();
    drive_mem(1'b1, 5'd12, 32'h10C, 32'd0, 3'd0, 2'd0);
    drive_md(1'b1, 5'd13, 32'hB3);
    exp_q.push_back({5'd12, 32'h10C});
    tick();
    idle();
    check("pre_rst_ready", {63'd0, md_ready_o}, 64'd0);
    #3 rst_i = 1'b0;
    #1;
    check("arst_ready", {63'd0, md_ready_o}, 64'd1);
    check("arst_busy", {63'd0, busy_o}, 64'd0);
    check("arst_we", {63'd0, wb_we_o}, 64'd0);
    tick();
    rst_i = 1'b1;
    tick();
    tick();
    check("post_rst_busy", {63'd0, busy_o}, 64'd0);

    // random loads with random pause
    for (int i = 0; i < 40; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_pause = ($urandom_range(0, 3) == 0);
      r_addr  = 5'($urandom_range(0, 31));
      r_alu   = $urandom;
      r_dmem  = $urandom;
      r_ld    = 3'($urandom_range(0, 7));
      r_bsel  = 2'($urandom_range(0, 3));
      drive_mem(r_we, r_addr, r_alu, r_dmem, r_ld, r_bsel);
      pause = r_pause;
      r_exp = model_align(r_ld, r_bsel, r_alu, r_dmem);
      if (!r_pause && r_we && (r_addr != 5'd0))
        exp_q.push_back({r_addr, r_exp});
      #1 check("fw_rand", {32'd0, fw_mem_o}, {32'd0, r_exp});
      tick();
    end
    idle();
    pause = 1'b0;
    tick();
    tick();
    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
